// File: rtl/fft_reorder_pkg.sv
// Shared constants and helpers for the FFT bit-reversed to natural-order reorder buffer.
package fft_reorder_pkg;

    localparam int FFT_N_LOG2 = 4;
    localparam int FFT_N      = 16;
    localparam int FFT_DW     = 16;
    localparam int FFT_WW     = 2 * FFT_DW;

    function automatic logic [FFT_N_LOG2-1:0] bitrev(input logic [FFT_N_LOG2-1:0] idx);
        logic [FFT_N_LOG2-1:0] rev;
        for (int i = 0; i < FFT_N_LOG2; i++) begin
            rev[i] = idx[FFT_N_LOG2-1-i];
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft_reorder_bank_mem.sv
// Ping-pong sample store: one write port, one registered read port, address = {bank, index}.
module fft_reorder_bank_mem
    import fft_reorder_pkg::*;
#(
    parameter int AW = FFT_N_LOG2 + 1,
    parameter int WW = FFT_WW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [WW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [WW-1:0] rd_data
);

    logic [WW-1:0] mem_r [2**AW];

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value between reads so the output data is stable when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= {WW{1'b0}};
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/fft_reorder.sv
// Reorders 16-point bit-reversed FFT frames into natural order through two ping-pong banks.
// Optional out_last_F end-of-frame flag is enabled by defining FFT_REORDER_LAST_EN.
module fft_reorder
    import fft_reorder_pkg::*;
#(
    parameter int DW     = FFT_DW,
    parameter int N_LOG2 = FFT_N_LOG2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_push,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    output logic          in_stall_F,
    output logic          out_push_F,
    output logic [DW-1:0] out_real_F,
    output logic [DW-1:0] out_imag_F,
    input  logic          out_stall
`ifdef FFT_REORDER_LAST_EN
    ,
    output logic          out_last_F
`endif
);

    localparam logic [N_LOG2-1:0] CNT_MAX = {N_LOG2{1'b1}};

    logic              wr_bank_r;
    logic              rd_bank_r;
    logic [N_LOG2-1:0] wr_cnt_r;
    logic [N_LOG2-1:0] rd_cnt_r;
    logic [1:0]        full_r;

    logic              accept_s;
    logic              wr_done_s;
    logic              rd_en_s;
    logic              rd_done_s;
    logic [1:0]        full_nxt_s;
    logic              wr_bank_nxt_s;
    logic [2*DW-1:0]   rd_data_s;

    assign accept_s  = in_push & ~in_stall_F;
    assign wr_done_s = accept_s & (wr_cnt_r == CNT_MAX);
    assign rd_en_s   = full_r[rd_bank_r] & ~out_stall;
    assign rd_done_s = rd_en_s & (rd_cnt_r == CNT_MAX);

    // Bank occupancy next state; a completing read and write always target different banks.
    always_comb begin
        full_nxt_s    = full_r;
        wr_bank_nxt_s = wr_bank_r;
        if (rd_done_s) begin
            full_nxt_s[rd_bank_r] = 1'b0;
        end else begin
            full_nxt_s[rd_bank_r] = full_r[rd_bank_r];
        end
        if (wr_done_s) begin
            full_nxt_s[wr_bank_r] = 1'b1;
            wr_bank_nxt_s         = ~wr_bank_r;
        end else begin
            wr_bank_nxt_s = wr_bank_r;
        end
    end

    // Control state; stall looks ahead so upstream never needs a skid buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank_r  <= 1'b0;
            rd_bank_r  <= 1'b0;
            wr_cnt_r   <= {N_LOG2{1'b0}};
            rd_cnt_r   <= {N_LOG2{1'b0}};
            full_r     <= 2'b00;
            in_stall_F <= 1'b0;
            out_push_F <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_cnt_r <= wr_cnt_r + N_LOG2'(1);
            end
            if (rd_en_s) begin
                rd_cnt_r <= rd_cnt_r + N_LOG2'(1);
            end
            if (rd_done_s) begin
                rd_bank_r <= ~rd_bank_r;
            end
            wr_bank_r  <= wr_bank_nxt_s;
            full_r     <= full_nxt_s;
            in_stall_F <= full_nxt_s[wr_bank_nxt_s];
            out_push_F <= rd_en_s;
        end
    end

`ifdef FFT_REORDER_LAST_EN
    // End-of-frame marker aligned with the last natural-order sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_last_F <= 1'b0;
        end else begin
            out_last_F <= rd_done_s;
        end
    end
`endif

    fft_reorder_bank_mem #(
        .AW(N_LOG2 + 1),
        .WW(2 * DW)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (accept_s),
        .wr_addr({wr_bank_r, wr_cnt_r}),
        .wr_data({in_real, in_imag}),
        .rd_en  (rd_en_s),
        .rd_addr({rd_bank_r, bitrev(rd_cnt_r)}),
        .rd_data(rd_data_s)
    );

    assign {out_real_F, out_imag_F} = rd_data_s;

endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder: reorder, streaming, back-pressure, skid, reset, optional last flag.
module tb_fft_reorder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_push;
    logic [15:0] in_real;
    logic [15:0] in_imag;
    logic        in_stall_F;
    logic        out_push_F;
    logic [15:0] out_real_F;
    logic [15:0] out_imag_F;
    logic        out_stall;
`ifdef FFT_REORDER_LAST_EN
    logic        out_last_F;
`endif

    always #5 clk = ~clk;

    fft_reorder dut (
        .clk       (clk),
        .reset     (reset),
        .in_push   (in_push),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .in_stall_F(in_stall_F),
        .out_push_F(out_push_F),
        .out_real_F(out_real_F),
        .out_imag_F(out_imag_F),
        .out_stall (out_stall)
`ifdef FFT_REORDER_LAST_EN
        ,
        .out_last_F(out_last_F)
`endif
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Natural-order output position j carries the sample pushed at position rev_tbl[j].
    logic [3:0] rev_tbl [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                 4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

    logic [31:0] obs_q [$];
    int          obs_cyc_q [$];
    logic        last_q [$];
    int          cyc = 0;
    bit          watch_stall = 1'b0;
    bit          stall_seen = 1'b0;
    bit          track_fall = 1'b0;
    int          fall_idx = -1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (out_push_F === 1'b1) begin
            obs_q.push_back({out_real_F, out_imag_F});
            obs_cyc_q.push_back(cyc);
`ifdef FFT_REORDER_LAST_EN
            last_q.push_back(out_last_F);
`endif
        end
        if (watch_stall && in_stall_F) stall_seen = 1'b1;
        if (track_fall && !in_stall_F && fall_idx < 0) fall_idx = obs_q.size();
    end

    task automatic push_one(input logic [15:0] r, input logic [15:0] i);
        in_push = 1'b1;
        in_real = r;
        in_imag = i;
        @(posedge clk);
        #1;
        in_push = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] r0, input logic [15:0] i0);
        for (int k = 0; k < 16; k++) push_one(r0 + 16'(k), i0 + 16'(k));
    endtask

    task automatic wait_outputs(input int n);
        int t;
        t = 0;
        while (obs_q.size() < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check_val("output_count", obs_q.size(), n);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [15:0] r0, input logic [15:0] i0);
        logic [31:0] exp;
        for (int j = 0; j < 16; j++) begin
            exp = {r0 + 16'(rev_tbl[j]), i0 + 16'(rev_tbl[j])};
            if (base + j < obs_q.size()) check_val(tag, obs_q[base+j], exp);
            else check_val({tag, "_missing"}, 32'hFFFF_FFFF, exp);
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc_q.delete();
        last_q.delete();
    endtask

    initial begin
        reset     = 1'b0;
        in_push   = 1'b0;
        in_real   = 16'h0000;
        in_imag   = 16'h0000;
        out_stall = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_push", out_push_F, 1'b0);
        check_val("rst_stall", in_stall_F, 1'b0);
        check_val("rst_real", out_real_F, 16'h0000);
        check_val("rst_imag", out_imag_F, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single frame: bit-reversal order and one-cycle latency
        push_frame(16'h0000, 16'h0100);
        @(negedge clk);
        check_val("latency_e", out_push_F, 1'b0);
        @(negedge clk);
        check_val("latency_e1", out_push_F, 1'b1);
        check_val("first_real", out_real_F, 16'h0000);
        wait_outputs(16);
        check_frame("bitrev", 0, 16'h0000, 16'h0100);
        clear_obs();

        // Three back-to-back frames, no stall
        stall_seen  = 1'b0;
        watch_stall = 1'b1;
        for (int f = 0; f < 3; f++) push_frame(16'h2000 + 16'(f * 16), 16'h3000 + 16'(f * 16));
        wait_outputs(48);
        watch_stall = 1'b0;
        check_val("b2b_no_stall", stall_seen, 1'b0);
        if (obs_cyc_q.size() == 48) check_val("b2b_contiguous", obs_cyc_q[47] - obs_cyc_q[0], 47);
        for (int f = 0; f < 3; f++) check_frame("b2b", f * 16, 16'h2000 + 16'(f * 16), 16'h3000 + 16'(f * 16));
        clear_obs();

        // Both banks full under back-pressure; extra pushes dropped
        out_stall = 1'b1;
        push_frame(16'h4000, 16'h4100);
        push_frame(16'h4010, 16'h4110);
        @(negedge clk);
        check_val("full_stall", in_stall_F, 1'b1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) push_one(16'hDEAD, 16'hBEEF);
        @(negedge clk);
        check_val("full_stall_hold", in_stall_F, 1'b1);
        check_val("full_no_output", obs_q.size(), 0);
        fall_idx   = -1;
        track_fall = 1'b1;
        @(posedge clk);
        #1;
        out_stall = 1'b0;
        wait_outputs(32);
        track_fall = 1'b0;
        check_val("stall_fall_idx", fall_idx, 16);
        check_frame("bp_f0", 0, 16'h4000, 16'h4100);
        check_frame("bp_f1", 16, 16'h4010, 16'h4110);
        clear_obs();

        // Downstream skid: 1-cycle stall every 3 cycles
        out_stall = 1'b1;
        push_frame(16'h5000, 16'h5100);
        for (int i = 0; i < 24; i++) begin
            out_stall = (i % 3 == 2);
            @(negedge clk);
            if (i % 3 == 2) check_val("skid_push_after_rise", out_push_F, 1'b1);
            if (i % 3 == 0 && i > 0) check_val("skid_gap", out_push_F, 1'b0);
            @(posedge clk);
            #1;
        end
        out_stall = 1'b0;
        wait_outputs(16);
        check_frame("skid", 0, 16'h5000, 16'h5100);
        clear_obs();

        // Reset in the middle of a frame
        for (int k = 0; k < 7; k++) push_one(16'h6000 + 16'(k), 16'h6100 + 16'(k));
        reset = 1'b0;
        @(negedge clk);
        check_val("mid_rst_push", out_push_F, 1'b0);
        check_val("mid_rst_stall", in_stall_F, 1'b0);
        check_val("mid_rst_real", out_real_F, 16'h0000);
        check_val("mid_rst_imag", out_imag_F, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        push_frame(16'h00A0, 16'h00B0);
        wait_outputs(16);
        repeat (20) @(negedge clk);
        check_val("mid_rst_only_new", obs_q.size(), 16);
        check_frame("mid_rst", 0, 16'h00A0, 16'h00B0);
        clear_obs();

`ifdef FFT_REORDER_LAST_EN
        push_frame(16'h7000, 16'h7100);
        push_frame(16'h7010, 16'h7110);
        wait_outputs(32);
        for (int j = 0; j < 32; j++) begin
            if (j < last_q.size()) check_val("last_flag", last_q[j], (j == 15 || j == 31) ? 1'b1 : 1'b0);
        end
        check_frame("last_f0", 0, 16'h7000, 16'h7100);
        check_frame("last_f1", 16, 16'h7010, 16'h7110);
        clear_obs();
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fft_reorder.md
Name: fft_reorder

Overview:
- Receiver for the FFT output push/stall stream.
- Accepts 16-point frames in bit-reversed index order, buffers them in a two-bank (ping-pong) memory, and re-emits each frame in natural order on a downstream push/stall interface.
- Sits between the FFT core output and downstream consumers (magnitude, host readout).
- Continuous back-to-back frames are sustained with no bubbles when downstream never stalls.

Parameters:
- DW, 16: width of each real/imag component.
- N_LOG2, 4: log2 of frame length; frame length N = 16.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- in_push  input  1  upstream sample valid.
- in_real  input  DW  upstream real component.
- in_imag  input  DW  upstream imag component.
- in_stall_F  output  1  registered; upstream must not push while high.
- out_push_F  output  1  registered downstream sample valid.
- out_real_F  output  DW  registered natural-order real component.
- out_imag_F  output  DW  registered natural-order imag component.
- out_stall  input  1  downstream back-pressure.

Behaviour:
- Reset (asynchronous, reset=0):
  - in_stall_F=0, out_push_F=0, out_real_F=0, out_imag_F=0.
  - wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, full[1:0]=0.
  - Memory contents are not reset.
  - Reset mid-frame discards all partial and buffered frames.
- Storage: 2 banks x N words x 2*DW bits; bank word = {real, imag}.
- Write side:
  - Accept when in_push=1 and in_stall_F=0.
  - Accepted sample is written to mem[wr_bank][wr_cnt]; wr_cnt increments and wraps N-1 -> 0.
  - On the accept at wr_cnt=N-1: full[wr_bank]<=1 and wr_bank toggles.
  - in_push=1 while in_stall_F=1 is a protocol violation: the sample is dropped and no state changes.
- in_stall_F:
  - Registered from next-state: high when full[next wr_bank] is set in the next state.
  - Therefore it rises on the edge that completes a frame whenever the other bank is still full.
  - No upstream skid is required.
- Read side, per edge:
  - If full[rd_bank]=1 and out_stall=0: out_push_F<=1 and {out_real_F,out_imag_F}<=mem[rd_bank][bitrev(rd_cnt)]. rd_cnt increments.
  - At rd_cnt=N-1: full[rd_bank]<=0, rd_bank toggles, rd_cnt<=0.
  - Otherwise: out_push_F<=0, and data outputs hold their last value.
  - bitrev reverses the N_LOG2 address bits, e.g. 1 -> 8, 3 -> 12.
- Downstream skid: out_stall is sampled at the edge. The consumer must accept one more push in the cycle after it raises out_stall.
- Latency: the last sample of a frame is accepted at edge E; the first natural-order output has out_push_F=1 after edge E+1.
- Simultaneous events:
  - Completing a write and completing a read on the same edge act on different banks; both updates apply.
  - A freshly filled bank is readable from the next edge.
- Throughput: 1 sample/cycle in and out; with out_stall=0 and one push per cycle, in_stall_F never asserts.

Optional Feature:
- Macro FFT_REORDER_LAST_EN.
- When defined: adds output out_last_F (1 bit, registered, reset 0). It is high with out_push_F on the N-th sample (rd_cnt=N-1) of each frame, and 0 otherwise.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds FFT_N_LOG2=4, FFT_N=16, FFT_DW=16, the {real,imag} word width 2*DW, and a bitrev function.
- One natural sub-module: fft_reorder_bank_mem, a 2xN x 2*DW memory with one write port and one registered read port, addressed by {bank, index}.

Test Plan:
- Bit-reversal order: push one frame with in_real=16'hk on k-th push, in_imag=16'h0100+k, k=0..15, out_stall=0 -> out_real_F sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with matching imag; first out_push_F is 1 cycle after the 16th accept.
- Back-to-back frames: 48 consecutive pushes (3 frames), out_stall=0 -> in_stall_F stays 0 throughout; 48 outputs, contiguous with no gaps, each frame correctly reordered.
- Full-buffer back-pressure: out_stall=1 held, push 32 samples -> in_stall_F=1 on the cycle after the 32nd accept; extra pushes are dropped. Release out_stall -> 32 correct outputs, and in_stall_F falls after the first frame is drained.
- Downstream skid: toggle out_stall 1-cycle high every 3 cycles during readout -> exactly one push occurs after each rise; no sample is lost or duplicated.
- Mid-frame reset: assert reset after 7 pushes, release, push a full frame of 16'hA0+k -> output contains only the new frame, reordered; all outputs read 0 while in reset.
- FFT_REORDER_LAST_EN defined: two frames -> out_last_F high only on the 16th and 32nd out_push_F.
